// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter: shares the single data-memory port between store-buffer
// load reads and committed-store drain writes, with anti-starvation and fence drain.
module lsu_bus_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SIZE_WIDTH   = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stbuf_bus_read_req,
    input  logic [ADDR_WIDTH-1:0] stbuf_bus_read_addr,
    input  logic [SIZE_WIDTH-1:0] stbuf_bus_read_size,
    input  logic                  stbuf_bus_write_req,
    input  logic [ADDR_WIDTH-1:0] stbuf_bus_write_addr,
    input  logic [SIZE_WIDTH-1:0] stbuf_bus_write_size,
    input  logic [DATA_WIDTH-1:0] stbuf_bus_data,
    input  logic                  stbuf_full,
    input  logic                  stbuf_all_empty,
    input  logic                  drain_req,
    output logic                  drain_done,
    output logic                  bus_stbuf_read_ack,
    output logic                  bus_stbuf_write_ack,
    output logic [DATA_WIDTH-1:0] bus_stbuf_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [SIZE_WIDTH-1:0] mem_size,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          wp;
    logic          grant_rd;
    logic          grant_wr;
    logic          ack_rd;
    logic          ack_wr;

    // Arbitrate in IDLE, detect completion while a transaction is in flight
    always_comb begin
        state_nxt = state;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        ack_rd    = 1'b0;
        ack_wr    = 1'b0;
        wp        = drain_req | stbuf_full |
                    (starve_cnt == CW'(STARVE_LIMIT));
        unique case (state)
            IDLE: begin
                if (wp && stbuf_bus_write_req) begin
                    grant_wr = 1'b1;
                end else if (!drain_req && stbuf_bus_read_req) begin
                    grant_rd = 1'b1;
                end else if (stbuf_bus_write_req) begin
                    grant_wr = 1'b1;
                end
                if (grant_wr) begin
                    state_nxt = WRITE;
                end else if (grant_rd) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (mem_ack) begin
                    ack_rd    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    ack_wr    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Count cycles a waiting store loses arbitration, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_wr) begin
            starve_cnt <= '0;
        end else if (stbuf_bus_write_req && state != WRITE &&
                     starve_cnt != CW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Latch the granted payload and hold mem_req until the memory acks
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_size  <= '0;
            mem_wdata <= '0;
        end else if (grant_wr) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= stbuf_bus_write_addr;
            mem_size  <= stbuf_bus_write_size;
            mem_wdata <= stbuf_bus_data;
        end else if (grant_rd) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= stbuf_bus_read_addr;
            mem_size  <= stbuf_bus_read_size;
        end else if (ack_rd || ack_wr) begin
            mem_req   <= 1'b0;
        end
    end

    // Acks are suppressed while reset is asserted so an aborted transfer never completes
    assign bus_stbuf_read_ack  = rst & ack_rd;
    assign bus_stbuf_write_ack = rst & ack_wr;
    assign bus_stbuf_data      = mem_rdata;
    assign drain_done          = rst & drain_req & stbuf_all_empty & (state == IDLE);

endmodule
